alu: RTL and testbench

- 64-bit integer ALU for the datapath execute stage.
- Computes AND/OR/ADD/SUB/SLT/NOR from a 4-bit operation code.
- Registers the result and a zero flag on the clock, with one-cycle latency.
- Feeds writeback and branch-compare logic; zero is used for beq-style decisions.

---
 rtl/alu.sv | 66 ++++++
 tb/tb_alu.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/alu.sv
// Registered integer ALU for the execute stage: one result per cycle, one-cycle latency.
// Define ALU_SHIFT_EN to add XOR and the SLL/SRL/SRA shift operations.
module alu #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALU_operation,
  output logic [WIDTH-1:0] ALU_result,
  output logic             zero
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;
`ifdef ALU_SHIFT_EN
  localparam logic [3:0] OP_XOR = 4'b0011;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SRL = 4'b0101;
  localparam logic [3:0] OP_SRA = 4'b1000;

  logic [SHW-1:0] shamt;
  assign shamt = B[SHW-1:0];
`endif

  logic [WIDTH-1:0] result_d, result_q;
  logic             slt_bit;

  assign slt_bit = ($signed(A) < $signed(B));

  always_comb begin
    result_d = '0;
    case (ALU_operation)
      OP_AND:  result_d = A & B;
      OP_OR:   result_d = A | B;
      OP_ADD:  result_d = A + B;
      OP_SUB:  result_d = A - B;
      OP_SLT:  result_d = {{(WIDTH-1){1'b0}}, slt_bit};
      OP_NOR:  result_d = ~(A | B);
`ifdef ALU_SHIFT_EN
      OP_XOR:  result_d = A ^ B;
      OP_SLL:  result_d = A << shamt;
      OP_SRL:  result_d = A >> shamt;
      OP_SRA:  result_d = $unsigned($signed(A) >>> shamt);
`endif
      default: result_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) result_q <= '0;
    else       result_q <= result_d;
  end

  // zero follows the register, never the live operands
  assign ALU_result = result_q;
  assign zero       = (result_q == '0);

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed test-plan vectors plus randomized traffic
// compared against a behavioural model; honours ALU_SHIFT_EN in both builds.
module tb_alu;

  localparam int W = 64;

  logic         clk;
  logic         reset;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic [3:0]   op_in;
  logic [W-1:0] alu_result;
  logic         zero;

  int checks;
  int errors;

  alu #(.WIDTH(W)) dut (
    .clk           (clk),
    .reset         (reset),
    .A             (a_in),
    .B             (b_in),
    .ALU_operation (op_in),
    .ALU_result    (alu_result),
    .zero          (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural reference: what each opcode means arithmetically
  function automatic logic [W-1:0] refModel(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [3:0] op);
    longint sa, sb;
    int     sh;
    sa = longint'(a);
    sb = longint'(b);
    sh = int'(b % 64);
    case (op)
      4'd0:  return a & b;
      4'd1:  return a | b;
      4'd2:  return W'(sa + sb);
      4'd6:  return W'(sa - sb);
      4'd7:  return (sa < sb) ? 64'd1 : 64'd0;
      4'd12: return ~(a | b);
`ifdef ALU_SHIFT_EN
      4'd3:  return a ^ b;
      4'd4:  return a << sh;
      4'd5:  return a >> sh;
      4'd8:  return W'(sa >>> sh);
`endif
      default: return '0;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, step past the edge, then check result and zero
  task automatic applyStimulus(input string tag, input logic rst, input logic [W-1:0] a,
                               input logic [W-1:0] b, input logic [3:0] op);
    logic [W-1:0] exp;
    reset = rst;
    a_in  = a;
    b_in  = b;
    op_in = op;
    exp   = rst ? '0 : refModel(a, b, op);
    @(posedge clk);
    #1;
    checkOutput({tag, ".result"}, alu_result, exp);
    checkOutput({tag, ".zero"}, {63'd0, zero}, {63'd0, exp == 0});
  endtask

  task automatic expectValue(input string tag, input logic [W-1:0] exp);
    checkOutput({tag, ".plan"}, alu_result, exp);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic [3:0]   rop;
    logic         rrst;
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    a_in   = '0;
    b_in   = '0;
    op_in  = '0;
    @(negedge clk);

    applyStimulus("rst0", 1'b1, 64'd45, 64'd67, 4'b0010);
    expectValue("rst0", 64'd0);
    applyStimulus("rst1", 1'b1, 64'd45, 64'd67, 4'b0010);
    applyStimulus("add_after_rst", 1'b0, 64'd45, 64'd67, 4'b0010);
    expectValue("add_after_rst", 64'd112);

    applyStimulus("and45", 1'b0, 64'd45, 64'd67, 4'b0000);
    expectValue("and45", 64'd1);
    applyStimulus("or45", 1'b0, 64'd45, 64'd67, 4'b0001);
    expectValue("or45", 64'd111);
    applyStimulus("add45", 1'b0, 64'd45, 64'd67, 4'b0010);
    applyStimulus("sub45", 1'b0, 64'd45, 64'd67, 4'b0110);
    expectValue("sub45", 64'hFFFF_FFFF_FFFF_FFEA);

    applyStimulus("sub_eq", 1'b0, 64'd33, 64'd33, 4'b0110);
    expectValue("sub_eq", 64'd0);
    applyStimulus("sub67", 1'b0, 64'd67, 64'd45, 4'b0110);
    expectValue("sub67", 64'd22);
    applyStimulus("and67", 1'b0, 64'd67, 64'd45, 4'b0000);
    applyStimulus("or67", 1'b0, 64'd67, 64'd45, 4'b0001);

    applyStimulus("add_wrap", 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'b0010);
    expectValue("add_wrap", 64'd0);
    applyStimulus("sub_borrow", 1'b0, 64'd0, 64'd1, 4'b0110);
    expectValue("sub_borrow", 64'hFFFF_FFFF_FFFF_FFFF);
    applyStimulus("slt_neg", 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'b0111);
    expectValue("slt_neg", 64'd1);
    applyStimulus("slt_pos", 1'b0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 4'b0111);
    expectValue("slt_pos", 64'd0);
    applyStimulus("nor0", 1'b0, 64'd0, 64'd0, 4'b1100);
    expectValue("nor0", 64'hFFFF_FFFF_FFFF_FFFF);
    applyStimulus("inv15", 1'b0, 64'd33, 64'd33, 4'b1111);
    expectValue("inv15", 64'd0);

    applyStimulus("sra", 1'b0, 64'h8000_0000_0000_0000, 64'd4, 4'b1000);
    applyStimulus("srl", 1'b0, 64'h8000_0000_0000_0000, 64'd4, 4'b0101);
    applyStimulus("sll", 1'b0, 64'd1, 64'h43, 4'b0100);
    applyStimulus("xor", 1'b0, 64'hF0F0, 64'h0FF0, 4'b0011);
`ifdef ALU_SHIFT_EN
    applyStimulus("sra_plan", 1'b0, 64'h8000_0000_0000_0000, 64'd4, 4'b1000);
    expectValue("sra_plan", 64'hF800_0000_0000_0000);
    applyStimulus("sll_plan", 1'b0, 64'd1, 64'h43, 4'b0100);
    expectValue("sll_plan", 64'd8);
`else
    applyStimulus("sll_off", 1'b0, 64'd1, 64'h43, 4'b0100);
    expectValue("sll_off", 64'd0);
`endif

    // Mid-stream reset then recovery
    applyStimulus("mid_rst", 1'b1, 64'd5, 64'd6, 4'b0010);
    applyStimulus("post_rst", 1'b0, 64'd5, 64'd6, 4'b0010);
    expectValue("post_rst", 64'd11);

    for (int i = 0; i < 400; i++) begin
      ra   = {$urandom, $urandom};
      rb   = {$urandom, $urandom};
      rop  = 4'($urandom_range(0, 15));
      rrst = ($urandom_range(0, 31) == 0);
      case ($urandom_range(0, 7))
        0: rb = ra;
        1: ra = 64'hFFFF_FFFF_FFFF_FFFF;
        2: rb = 64'($urandom_range(0, 200));
        3: ra = {1'b1, 63'($urandom)};
        default: ;
      endcase
      applyStimulus($sformatf("rand%0d_op%0d", i, rop), rrst, ra, rb, rop);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
